tt_um_jleugeri_ttt_scheduler: RTL and testbench
===============================================

// Module: tt_um_jleugeri_ttt_scheduler
// PURPOSE
//  Stage sequencer for the tick-tock-tokens core. Decodes the 4-bit instruction and walks the system through
//  WAIT -> UPDATE -> CHECK -> NETWORK. Sweeps the processor index, fetches CSR indptr ranges for firing
//  processors and streams their connection IDs to the network datapath under ready/valid.
// PARAMETERS
//  NUM_PROCESSORS   15                           processor count
//  NUM_CONNECTIONS  225                          connection count (indptr value range 0..NUM_CONNECTIONS)
//  PROC_BITS        $clog2(NUM_PROCESSORS+1)     processor/indptr address width
//  CONN_BITS        $clog2(NUM_CONNECTIONS+1)    connection ID / indptr data width
//  TICK_BITS        16                           tick counter width (optional feature only)
// PORTS
//  clock_fast        in   1          single clock; all logic is on its rising edge
//  reset             in   1          synchronous, active-high
//  instruction       in   4          opcode: 0000 nop, 0001 input, 0010 advance, 1xxx program
//  stage             out  2          00 WAIT, 01 UPDATE, 10 CHECK, 11 NETWORK
//  input_strobe      out  1          1-cycle pulse; 0001 accepted
//  prog_strobe       out  1          1-cycle pulse; 1xxx accepted
//  cmd_reject        out  1          1-cycle pulse; opcode illegal or illegal in current stage
//  proc_idx          out  PROC_BITS  processor under update/check
//  proc_update_en    out  1          update proc_idx this cycle
//  proc_check_en     out  1          check proc_idx this cycle
//  fire_start        in   1          start token from proc_idx, valid when proc_check_en
//  fire_stop         in   1          stop token from proc_idx, valid when proc_check_en
//  indptr_rd_en      out  1          indptr read request
//  indptr_addr       out  PROC_BITS  indptr read address
//  indptr_rdata      in   CONN_BITS  read data; valid 1 cycle after indptr_rd_en
//  conn_valid        out  1          conn_id/conn_startstop valid
//  conn_ready        in   1          network accepts when conn_valid & conn_ready
//  conn_id           out  CONN_BITS  connection to transmit
//  conn_startstop    out  2          {stop,start} of the firing processor
//  processor_id_out  out  PROC_BITS  ID of the firing processor
//  token_startstop   out  2          {stop,start} of the firing processor
//  output_valid      out  1          1-cycle pulse per firing event
//  tick_count        out  TICK_BITS  completed advances (0 when feature compiled out)
// BEHAVIOUR
//  Reset: stage=00; proc_idx=0; every strobe, enable and valid = 0; conn_id, processor_id_out,
//   token_startstop, tick_count = 0. Reset at any point, including mid-NETWORK, aborts to WAIT.
//  WAIT: 0000 -> stay. 0001 -> input_strobe. 1xxx -> prog_strobe. 0010 -> stage=01, proc_idx=0.
//   0011 and 01xx -> cmd_reject. All strobes are registered and rise the cycle after the opcode is sampled.
//  Outside WAIT: instruction is ignored except 0001 and 1xxx, which pulse cmd_reject; 0000 and 0010 are silent.
//  UPDATE: proc_update_en=1 for proc_idx 0..NUM_PROCESSORS-1, one per cycle (NUM_PROCESSORS cycles total),
//   then stage=10 with proc_idx=0.
//  CHECK: proc_check_en=1 for one cycle per processor.
//   - No fire: proc_idx advances; after the last index, stage=00.
//   - fire_start|fire_stop: latch p=proc_idx and ss={stop,start}. Next cycle: output_valid=1,
//     processor_id_out=p, token_startstop=ss, stage=11.
//  NETWORK sub-states:
//   - LO: rd addr p.
//   - HI: capture lo; rd addr p+1.
//   - STREAM: capture hi; walk c=lo..hi-1 with conn_valid=1, conn_id=c, conn_startstop=ss.
//   - c advances only on conn_valid&conn_ready; while conn_ready=0, conn_id/conn_startstop hold stable.
//   - hi<=lo (empty or malformed range): zero connections, no conn_valid.
//   - Exit: back to CHECK at p+1, or stage=00 if p was the last processor. Minimum 3 cycles per firing.
//  Comparisons are unsigned at CONN_BITS. indptr address p+1 never exceeds NUM_PROCESSORS.
// CONFIGURATION
//  TTT_SCHED_TICK_COUNTER_EN
//   - defined: tick_count increments (wrapping) on each accepted 0010.
//   - undefined: tick_count is tied to 0 and no counter flops are built.
// STRUCTURE
//  Package tt_um_jleugeri_ttt_pkg holds:
//   - stage_t enum {WAIT, UPDATE, CHECK, NETWORK};
//   - opcode localparams (OP_NOP, OP_INPUT, OP_ADVANCE, OP_PROG_*);
//   - net_state_t enum {NET_LO, NET_HI, NET_STREAM}.
//  Sub-module tt_um_jleugeri_ttt_range_walker: indptr fetch plus lo..hi-1 ready/valid streaming;
//   start/done handshake to the top-level FSM.
// TESTING
//  1 Reset held 2 cycles mid-STREAM -> next cycle stage=00, conn_valid=0, proc_idx=0, output_valid=0.
//  2 0010 in WAIT, no fires -> stage=01 for 15 cycles, 10 for 15 cycles, then 00; 0000 afterwards keeps 00.
//  3 Proc 3 fire_start; indptr[3]=10, indptr[4]=13; conn_ready=1 ->
//    output_valid with processor_id_out=3, token_startstop=01; conn_id 10,11,12 on consecutive cycles,
//    conn_startstop=01; then proc_check_en with proc_idx=4.
//  4 As test 3 but conn_ready=0 for 3 cycles while conn_id=11 -> conn_id holds 11; 12 follows; no drop, no duplicate.
//  5 Proc 14 fires start+stop; indptr[14]=indptr[15]=225 -> token_startstop=11, no conn_valid, stage=00.
//  6 1001 during UPDATE -> cmd_reject, no prog_strobe; 1001 in WAIT -> prog_strobe.
//    With TTT_SCHED_TICK_COUNTER_EN, three advances -> tick_count=3.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// Shared types and opcodes for the tick-tock-tokens stage sequencer.
package tt_um_jleugeri_ttt_pkg;

  typedef enum logic [1:0] {
    StWait    = 2'b00,
    StUpdate  = 2'b01,
    StCheck   = 2'b10,
    StNetwork = 2'b11
  } stage_t;

  typedef enum logic [1:0] {
    NetLo,
    NetHi,
    NetStream
  } net_state_t;

  localparam logic [3:0] OpNop     = 4'b0000;
  localparam logic [3:0] OpInput   = 4'b0001;
  localparam logic [3:0] OpAdvance = 4'b0010;

  // Every 1xxx opcode is a program write.
  function automatic logic is_prog(logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_range_walker.sv
// Fetches indptr[p], indptr[p+1] and streams connection IDs lo..hi-1 under ready/valid.
module tt_um_jleugeri_ttt_range_walker
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter int unsigned ProcBits = 4,
  parameter int unsigned ConnBits = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ProcBits-1:0] proc_i,
  output logic                rd_en_o,
  output logic [ProcBits-1:0] rd_addr_o,
  input  logic [ConnBits-1:0] rd_data_i,
  output logic                conn_valid_o,
  input  logic                conn_ready_i,
  output logic [ConnBits-1:0] conn_id_o,
  output logic                done_o
);

  net_state_t          state_q;
  logic                busy_q;
  logic                loaded_q;
  logic [ConnBits-1:0] lo_q, hi_q, cid_q;
  logic                last_conn;
  logic                range_empty;

  assign last_conn   = ConnBits'(cid_q + 1'b1) == hi_q;
  // In the first STREAM cycle rd_data_i carries indptr[p+1].
  assign range_empty = !(rd_data_i > lo_q);

  assign rd_en_o      = busy_q && (state_q == NetLo || state_q == NetHi);
  assign rd_addr_o    = (state_q == NetHi) ? ProcBits'(proc_i + 1'b1) : proc_i;
  assign conn_valid_o = busy_q && state_q == NetStream && loaded_q;
  assign conn_id_o    = cid_q;
  assign done_o       = busy_q && state_q == NetStream &&
                        (loaded_q ? (conn_ready_i && last_conn) : range_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= NetLo;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      cid_q    <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q   <= 1'b1;
        state_q  <= NetLo;
        loaded_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        NetLo: state_q <= NetHi;
        NetHi: begin
          lo_q    <= rd_data_i;
          state_q <= NetStream;
        end
        NetStream: begin
          if (!loaded_q) begin
            hi_q  <= rd_data_i;
            cid_q <= lo_q;
            if (range_empty) busy_q <= 1'b0;
            else             loaded_q <= 1'b1;
          end else if (conn_ready_i) begin
            if (last_conn) begin
              busy_q   <= 1'b0;
              loaded_q <= 1'b0;
            end else begin
              cid_q <= ConnBits'(cid_q + 1'b1);
            end
          end
        end
        default: state_q <= NetLo;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Stage sequencer WAIT -> UPDATE -> CHECK -> NETWORK for the tick-tock-tokens core.
// Optional tick counter enabled by defining TTT_SCHED_TICK_COUNTER_EN.
module tt_um_jleugeri_ttt_scheduler
  import tt_um_jleugeri_ttt_pkg::*;
#(
  parameter int unsigned NUM_PROCESSORS  = 15,
  parameter int unsigned NUM_CONNECTIONS = 225,
  parameter int unsigned PROC_BITS       = $clog2(NUM_PROCESSORS + 1),
  parameter int unsigned CONN_BITS       = $clog2(NUM_CONNECTIONS + 1),
  parameter int unsigned TICK_BITS       = 16
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic [3:0]           instruction,
  output logic [1:0]           stage,
  output logic                 input_strobe,
  output logic                 prog_strobe,
  output logic                 cmd_reject,
  output logic [PROC_BITS-1:0] proc_idx,
  output logic                 proc_update_en,
  output logic                 proc_check_en,
  input  logic                 fire_start,
  input  logic                 fire_stop,
  output logic                 indptr_rd_en,
  output logic [PROC_BITS-1:0] indptr_addr,
  input  logic [CONN_BITS-1:0] indptr_rdata,
  output logic                 conn_valid,
  input  logic                 conn_ready,
  output logic [CONN_BITS-1:0] conn_id,
  output logic [1:0]           conn_startstop,
  output logic [PROC_BITS-1:0] processor_id_out,
  output logic [1:0]           token_startstop,
  output logic                 output_valid,
  output logic [TICK_BITS-1:0] tick_count
);

  localparam logic [PROC_BITS-1:0] LastProc = PROC_BITS'(NUM_PROCESSORS - 1);

  stage_t stage_q;
  logic   walk_start, walk_done;

  assign walk_start     = (stage_q == StCheck) && (fire_start || fire_stop);
  assign stage          = stage_q;
  assign conn_startstop = token_startstop;

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      stage_q          <= StWait;
      proc_idx         <= '0;
      proc_update_en   <= 1'b0;
      proc_check_en    <= 1'b0;
      input_strobe     <= 1'b0;
      prog_strobe      <= 1'b0;
      cmd_reject       <= 1'b0;
      output_valid     <= 1'b0;
      processor_id_out <= '0;
      token_startstop  <= 2'b00;
    end else begin
      input_strobe <= 1'b0;
      prog_strobe  <= 1'b0;
      cmd_reject   <= 1'b0;
      output_valid <= 1'b0;

      if (stage_q == StWait) begin
        if (is_prog(instruction)) begin
          prog_strobe <= 1'b1;
        end else begin
          case (instruction)
            OpNop, OpAdvance: ;
            OpInput:          input_strobe <= 1'b1;
            default:          cmd_reject   <= 1'b1;
          endcase
        end
      end else if (instruction == OpInput || is_prog(instruction)) begin
        cmd_reject <= 1'b1;
      end

      unique case (stage_q)
        StWait: begin
          if (instruction == OpAdvance) begin
            stage_q        <= StUpdate;
            proc_idx       <= '0;
            proc_update_en <= 1'b1;
          end
        end
        StUpdate: begin
          if (proc_idx == LastProc) begin
            stage_q        <= StCheck;
            proc_idx       <= '0;
            proc_update_en <= 1'b0;
            proc_check_en  <= 1'b1;
          end else begin
            proc_idx <= PROC_BITS'(proc_idx + 1'b1);
          end
        end
        StCheck: begin
          if (fire_start || fire_stop) begin
            stage_q          <= StNetwork;
            proc_check_en    <= 1'b0;
            output_valid     <= 1'b1;
            processor_id_out <= proc_idx;
            token_startstop  <= {fire_stop, fire_start};
          end else if (proc_idx == LastProc) begin
            stage_q       <= StWait;
            proc_idx      <= '0;
            proc_check_en <= 1'b0;
          end else begin
            proc_idx <= PROC_BITS'(proc_idx + 1'b1);
          end
        end
        StNetwork: begin
          // proc_idx holds the firing processor for the whole NETWORK stage.
          if (walk_done) begin
            if (proc_idx == LastProc) begin
              stage_q  <= StWait;
              proc_idx <= '0;
            end else begin
              stage_q       <= StCheck;
              proc_idx      <= PROC_BITS'(proc_idx + 1'b1);
              proc_check_en <= 1'b1;
            end
          end
        end
        default: stage_q <= StWait;
      endcase
    end
  end

  tt_um_jleugeri_ttt_range_walker #(
    .ProcBits (PROC_BITS),
    .ConnBits (CONN_BITS)
  ) u_range_walker (
    .clk_i        (clock_fast),
    .rst_i        (reset),
    .start_i      (walk_start),
    .proc_i       (processor_id_out),
    .rd_en_o      (indptr_rd_en),
    .rd_addr_o    (indptr_addr),
    .rd_data_i    (indptr_rdata),
    .conn_valid_o (conn_valid),
    .conn_ready_i (conn_ready),
    .conn_id_o    (conn_id),
    .done_o       (walk_done)
  );

`ifdef TTT_SCHED_TICK_COUNTER_EN
  logic [TICK_BITS-1:0] tick_q;

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      tick_q <= '0;
    end else if (stage_q == StWait && instruction == OpAdvance) begin
      tick_q <= TICK_BITS'(tick_q + 1'b1);
    end
  end

  assign tick_count = tick_q;
`else
  assign tick_count = '0;
`endif

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Directed bench for tt_um_jleugeri_ttt_scheduler: opcode table plus multi-cycle sequences.
module tb_tt_um_jleugeri_ttt_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] instruction = 4'b0000;
  logic [1:0] stage;
  logic       input_strobe, prog_strobe, cmd_reject;
  logic [3:0] proc_idx;
  logic       proc_update_en, proc_check_en;
  logic       fire_start, fire_stop;
  logic       indptr_rd_en;
  logic [3:0] indptr_addr;
  logic [7:0] indptr_rdata = 8'd0;
  logic       conn_valid;
  logic       conn_ready = 1'b1;
  logic [7:0] conn_id;
  logic [1:0] conn_startstop;
  logic [3:0] processor_id_out;
  logic [1:0] token_startstop;
  logic       output_valid;
  logic [15:0] tick_count;

  logic [15:0] start_mask = '0;
  logic [15:0] stop_mask  = '0;
  logic [7:0]  indptr_mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Processor array responder and indptr memory with one-cycle read latency.
  assign fire_start = proc_check_en && start_mask[proc_idx];
  assign fire_stop  = proc_check_en && stop_mask[proc_idx];

  always @(posedge clk) if (indptr_rd_en) indptr_rdata <= indptr_mem[indptr_addr];

  tt_um_jleugeri_ttt_scheduler dut (
    .clock_fast       (clk),
    .reset            (reset),
    .instruction      (instruction),
    .stage            (stage),
    .input_strobe     (input_strobe),
    .prog_strobe      (prog_strobe),
    .cmd_reject       (cmd_reject),
    .proc_idx         (proc_idx),
    .proc_update_en   (proc_update_en),
    .proc_check_en    (proc_check_en),
    .fire_start       (fire_start),
    .fire_stop        (fire_stop),
    .indptr_rd_en     (indptr_rd_en),
    .indptr_addr      (indptr_addr),
    .indptr_rdata     (indptr_rdata),
    .conn_valid       (conn_valid),
    .conn_ready       (conn_ready),
    .conn_id          (conn_id),
    .conn_startstop   (conn_startstop),
    .processor_id_out (processor_id_out),
    .token_startstop  (token_startstop),
    .output_valid     (output_valid),
    .tick_count       (tick_count)
  );

  typedef struct {
    logic [3:0] instr;
    logic [1:0] exp_stage;
    logic       exp_input;
    logic       exp_prog;
    logic       exp_reject;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instruction = 4'b0000;
    conn_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_advance();
    instruction = 4'b0010;
    @(negedge clk);
    instruction = 4'b0000;
  endtask

  task automatic wait_wait_stage(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (stage == 2'b00) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic run_fire(input string tag, input int p, input logic [1:0] ss, input int lo,
                          input int hi, input int stall_id, input int stall_n,
                          input int exp_net_cycles);
    int  k;
    int  stall_left;
    int  got[$];
    bit  seen;
    int  exp_n;
    start_mask = '0;
    stop_mask  = '0;
    start_mask[p] = ss[0];
    stop_mask[p]  = ss[1];
    indptr_mem[p]     = 8'(lo);
    indptr_mem[p + 1] = 8'(hi);
    do_reset();
    do_advance();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (output_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " output_valid seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, " processor_id_out"}, processor_id_out, p);
      chk({tag, " token_startstop"}, token_startstop, ss);
      chk({tag, " stage network"}, stage, 3);
      k = 0;
      stall_left = stall_n;
      while (stage == 2'b11 && k < 100) begin
        k++;
        if (conn_valid) begin
          chk({tag, " conn_startstop"}, conn_startstop, ss);
          if (stall_left > 0 && (stall_left < stall_n || conn_id == 8'(stall_id))) begin
            chk({tag, " conn_id held"}, conn_id, stall_id);
            conn_ready = 1'b0;
            stall_left--;
          end else begin
            conn_ready = 1'b1;
            got.push_back(int'(conn_id));
          end
        end else begin
          conn_ready = 1'b1;
        end
        @(negedge clk);
      end
      conn_ready = 1'b1;
      exp_n = (hi > lo) ? hi - lo : 0;
      chk({tag, " network cycles"}, k, exp_net_cycles);
      chk({tag, " conn count"}, got.size(), exp_n);
      for (int i = 0; i < got.size() && i < exp_n; i++) chk({tag, " conn_id seq"}, got[i], lo + i);
      if (p == 14) begin
        chk({tag, " exit stage"}, stage, 0);
      end else begin
        chk({tag, " exit stage"}, stage, 2);
        chk({tag, " exit check_en"}, proc_check_en, 1);
        chk({tag, " exit proc_idx"}, proc_idx, p + 1);
      end
    end
    start_mask = '0;
    stop_mask  = '0;
    wait_wait_stage({tag, " drains to wait"});
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 16; i++) indptr_mem[i] = 8'd0;

    vecs[0]  = '{4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'b1000, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0011, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'b0100, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{4'b0111, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'b1001, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'b0010, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b1001, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'b0001, 2'd1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0010, 2'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'b1110, 2'd1, 1'b0, 1'b0, 1'b1};

    // Reset state
    do_reset();
    chk("reset stage", stage, 0);
    chk("reset proc_idx", proc_idx, 0);
    chk("reset strobes", {input_strobe, prog_strobe, cmd_reject}, 0);
    chk("reset enables", {proc_update_en, proc_check_en, indptr_rd_en}, 0);
    chk("reset valids", {conn_valid, output_valid}, 0);
    chk("reset conn_id", conn_id, 0);
    chk("reset processor_id_out", processor_id_out, 0);
    chk("reset token_startstop", token_startstop, 0);
    chk("reset tick_count", tick_count, 0);

    // Opcode decode table
    for (int i = 0; i < 14; i++) begin
      instruction = vecs[i].instr;
      @(negedge clk);
      chk($sformatf("vec%0d stage", i), stage, vecs[i].exp_stage);
      chk($sformatf("vec%0d input_strobe", i), input_strobe, vecs[i].exp_input);
      chk($sformatf("vec%0d prog_strobe", i), prog_strobe, vecs[i].exp_prog);
      chk($sformatf("vec%0d cmd_reject", i), cmd_reject, vecs[i].exp_reject);
    end
    instruction = 4'b0000;
    wait_wait_stage("table run drains");

    // Idle advance: 15 update cycles, 15 check cycles, back to WAIT
    do_reset();
    do_advance();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("update stage c%0d", i), stage, 1);
      chk($sformatf("update idx c%0d", i), proc_idx, i);
      chk($sformatf("update en c%0d", i), proc_update_en, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("check stage c%0d", i), stage, 2);
      chk($sformatf("check idx c%0d", i), proc_idx, i);
      chk($sformatf("check en c%0d", i), {proc_update_en, proc_check_en}, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk("idle after check", stage, 0);
      chk("idle check_en off", proc_check_en, 0);
      @(negedge clk);
    end

    run_fire("fire3", 3, 2'b01, 10, 13, -1, 0, 6);
    run_fire("stall3", 3, 2'b01, 10, 13, 11, 3, 9);
    run_fire("fire14", 14, 2'b11, 225, 225, -1, 0, 3);
    run_fire("bad5", 5, 2'b10, 40, 30, -1, 0, 3);

    // Reset in the middle of a stalled stream
    start_mask = '0;
    start_mask[3] = 1'b1;
    indptr_mem[3] = 8'd10;
    indptr_mem[4] = 8'd13;
    do_reset();
    do_advance();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (conn_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midstream conn_valid seen", int'(seen), 1);
    conn_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midreset stage", stage, 0);
    chk("midreset conn_valid", conn_valid, 0);
    chk("midreset proc_idx", proc_idx, 0);
    chk("midreset output_valid", output_valid, 0);
    @(negedge clk);
    chk("midreset stays wait", stage, 0);
    conn_ready = 1'b1;
    start_mask = '0;

    // Tick counter after three idle advances
    do_reset();
    for (int n = 0; n < 3; n++) begin
      do_advance();
      wait_wait_stage("tick run drains");
    end
`ifdef TTT_SCHED_TICK_COUNTER_EN
    chk("tick_count", tick_count, 3);
`else
    chk("tick_count", tick_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
